gru_mac_smq: RTL and testbench

- Sequential sign-magnitude fixed-point multiply-accumulate stage for the GRU datapath.
- Consumes a stream of (input, weight) pairs over a valid/ready handshake and forms their dot product.
- Emits one 16-bit sign-magnitude pre-activation per frame. This is the upstream feeder of the gate adder / bias-add stage.
- Word format matches the adder: bit 15 = sign, bits 14:0 = magnitude, FRAC fractional bits.

---
 rtl/gru_mac_smq.sv | 171 +++++++++++++++++
 tb/tb_gru_mac_smq.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/gru_mac_smq.sv
// -----------------------------------------------------------------------------
// gru_mac_smq -- sequential sign-magnitude fixed-point multiply-accumulate
//
// Forms the dot product of a frame of (x, w) pairs and emits one 16-bit
// sign-magnitude pre-activation per frame for the gate adder / bias-add stage.
// Word format: bit 15 = sign, bits 14:0 = magnitude with FRAC fractional bits.
//
// Two-stage datapath:
//   stage 1  multiply the magnitudes, rescale, saturate to 15 bits and register
//            the product as ACC_W-bit two's complement with its last flag
//   stage 2  add the product to the accumulator (clamped to the symmetric
//            ACC_W range); on the frame's last product convert to sign-magnitude
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst        asynchronous reset, active low
//   in_valid   input pair valid
//   in_ready   stage can accept a pair (ACC state only)
//   in_x       sign-magnitude operand
//   in_w       sign-magnitude weight
//   in_last    marks the final pair of the frame (used only on a transfer)
//   out_valid  result valid (held until out_ready)
//   out_ready  downstream accepts the result
//   out_sum    sign-magnitude dot product, stable while out_valid=1
//   out_ovf    saturation occurred anywhere in this frame
// -----------------------------------------------------------------------------
module gru_mac_smq #(
  parameter int FRAC  = 8,
  parameter int ACC_W = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_x,
  input  logic [15:0] in_w,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_sum,
  output logic        out_ovf
);

  typedef enum logic [1:0] {
    S_ACC   = 2'd0,
    S_FLUSH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  // Symmetric accumulator bounds, held one bit wider than the accumulator so
  // the raw sum can be compared against them without wrapping.
  localparam logic signed [ACC_W:0] ACC_MAX = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] ACC_MIN = -ACC_MAX;

  state_t state, state_nxt;

  logic                    accept;
  logic                    p_valid;
  logic                    p_last;
  logic signed [ACC_W-1:0] p_val;
  logic signed [ACC_W-1:0] acc;
  logic                    first;
  logic                    ovf;

  // ---------------------------------------------------------------------------
  // Stage 1: magnitude multiply, rescale, 15-bit saturation, sign attach
  // ---------------------------------------------------------------------------
  logic [29:0]             prod_full;
  logic [29:0]             prod_shr;
  logic                    mul_ovf;
  logic [14:0]             mul_mag;
  logic                    mul_neg;
  logic signed [ACC_W-1:0] p_next;

  assign prod_full = 30'(in_x[14:0]) * 30'(in_w[14:0]);
  assign prod_shr  = prod_full >> FRAC;
  assign mul_ovf   = |prod_shr[29:15];
  assign mul_mag   = mul_ovf ? 15'h7FFF : prod_shr[14:0];
  // A zero magnitude is always positive, so -0 operands behave as zero.
  assign mul_neg   = (in_x[15] ^ in_w[15]) && (mul_mag != 15'd0);
  assign p_next    = mul_neg ? -$signed(ACC_W'(mul_mag)) : $signed(ACC_W'(mul_mag));

  // ---------------------------------------------------------------------------
  // Stage 2: accumulate with clamp, then sign-magnitude conversion
  // ---------------------------------------------------------------------------
  logic signed [ACC_W:0]   acc_sum;
  logic                    acc_ovf;
  logic signed [ACC_W-1:0] acc_new;
  logic [ACC_W-1:0]        acc_abs;
  logic                    s16_ovf;
  logic [15:0]             s16;

  // The first product of a frame starts from zero rather than from acc.
  assign acc_sum = (first ? '0 : (ACC_W+1)'(acc)) + (ACC_W+1)'(p_val);
  assign acc_ovf = (acc_sum > ACC_MAX) || (acc_sum < ACC_MIN);
  assign acc_new = (acc_sum > ACC_MAX) ? ACC_W'(ACC_MAX) :
                   (acc_sum < ACC_MIN) ? ACC_W'(ACC_MIN) :
                                         ACC_W'(acc_sum);
  // acc_new never reaches -2^(ACC_W-1), so its negation always fits.
  assign acc_abs = acc_new[ACC_W-1] ? ACC_W'(-acc_new) : ACC_W'(acc_new);
  assign s16_ovf = |acc_abs[ACC_W-1:15];
  assign s16     = {acc_new[ACC_W-1], s16_ovf ? 15'h7FFF : acc_abs[14:0]};

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  assign accept = in_valid && in_ready;

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      S_ACC: begin
        in_ready = rst;
        if (accept && in_last) state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        if (p_valid && p_last) state_nxt = S_HOLD;
      end
      S_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_ACC;
      end
      default: state_nxt = S_ACC;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of the others, whatever the statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_ACC;
      p_valid <= 1'b0;
      p_last  <= 1'b0;
      p_val   <= '0;
      acc     <= '0;
      first   <= 1'b1;
      ovf     <= 1'b0;
      out_sum <= 16'h0000;
      out_ovf <= 1'b0;
    end else begin
      state   <= state_nxt;
      p_valid <= accept;
      if (accept) begin
        p_val  <= p_next;
        p_last <= in_last;
      end

      if (state == S_HOLD && out_ready) begin
        // Result consumed: open a fresh frame.
        acc   <= '0;
        first <= 1'b1;
        ovf   <= 1'b0;
      end else begin
        ovf <= ovf | (accept && mul_ovf) | (p_valid && acc_ovf);
        if (p_valid) begin
          acc   <= acc_new;
          first <= 1'b0;
          if (p_last) begin
            out_sum <= s16;
            out_ovf <= ovf | acc_ovf | s16_ovf;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_gru_mac_smq.sv
// -----------------------------------------------------------------------------
// tb_gru_mac_smq -- directed self-checking bench for gru_mac_smq (FRAC=8,
// ACC_W=24). Inputs are driven 1 time unit after the rising edge and outputs
// are sampled at the same point, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_gru_mac_smq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_x = 16'h0000;
  logic [15:0] in_w = 16'h0000;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_sum;
  logic        out_ovf;

  int n_checks = 0;
  int n_errors = 0;

  gru_mac_smq #(.FRAC(8), .ACC_W(24)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_w      (in_w),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one pair and hold it until the handshake fires (bounded).
  task automatic send(input logic [15:0] x, input logic [15:0] w, input logic last);
    int n;
    in_x     = x;
    in_w     = w;
    in_last  = last;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("send_ready", {15'd0, in_ready}, 16'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Wait (bounded) for a result, compare it, then consume it.
  task automatic take(input string tag, input logic [15:0] exp_sum, input logic exp_ovf);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, {15'd0, out_valid}, 16'd1);
    check({tag, "_sum"}, out_sum, exp_sum);
    check({tag, "_ovf"}, {15'd0, out_ovf}, {15'd0, exp_ovf});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_rdy_after"}, {15'd0, in_ready}, 16'd1);
    check({tag, "_vld_after"}, {15'd0, out_valid}, 16'd0);
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_valid", {15'd0, out_valid}, 16'd0);
    check("rst_sum", out_sum, 16'h0000);
    check("rst_ovf", {15'd0, out_ovf}, 16'd0);
    check("rst_ready_low", {15'd0, in_ready}, 16'd0);
    tick();
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("rst_ready_high", {15'd0, in_ready}, 16'd1);

    // Single pair: 2.0 * -1.5 = -3.0, with exact output latency
    send(16'h0200, 16'h8180, 1'b1);
    check("lat_after_accept", {15'd0, out_valid}, 16'd0);
    check("lat_ready_flush", {15'd0, in_ready}, 16'd0);
    tick();
    check("lat_next_edge", {15'd0, out_valid}, 16'd1);
    take("single", 16'h8300, 1'b0);

    // Two-pair frame: -3.0 + 1.0 = -2.0
    send(16'h0200, 16'h8180, 1'b0);
    send(16'h0100, 16'h0100, 1'b1);
    take("frame2", 16'h8200, 1'b0);

    // Next frame proves the accumulator was cleared: 1.5 * 2.0 = 3.0
    send(16'h0180, 16'h0200, 1'b1);
    tick();
    tick();
    // Backpressure: result held, input blocked, offered pairs ignored
    out_ready = 1'b0;
    in_x      = 16'h7FFF;
    in_w      = 16'h7FFF;
    in_last   = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_sum", out_sum, 16'h0300);
      check("bp_valid", {15'd0, out_valid}, 16'd1);
      check("bp_ready", {15'd0, in_ready}, 16'd0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    take("clear", 16'h0300, 1'b0);

    // Negative zero operand
    send(16'h8000, 16'h0100, 1'b1);
    take("negzero", 16'h0000, 1'b0);

    // Multiplier saturation, then a clean frame has no sticky overflow
    send(16'h7FFF, 16'h7FFF, 1'b1);
    take("mulsat", 16'h7FFF, 1'b1);
    send(16'h0100, 16'h0100, 1'b1);
    take("postsat", 16'h0100, 1'b0);

    // 16-bit output saturation from the sum, both signs
    send(16'h7F00, 16'h0100, 1'b0);
    send(16'h7F00, 16'h0100, 1'b1);
    take("sat16_pos", 16'h7FFF, 1'b1);
    send(16'hFF00, 16'h0100, 1'b0);
    send(16'hFF00, 16'h0100, 1'b1);
    take("sat16_neg", 16'hFFFF, 1'b1);

    // Idle gap inside a frame: 3.0 + (-0.5) = 2.5
    send(16'h0100, 16'h0300, 1'b0);
    tick();
    tick();
    tick();
    send(16'h8100, 16'h0080, 1'b1);
    take("gap", 16'h0280, 1'b0);

    // Reset after 2 of 3 pairs: partial frame discarded
    send(16'h0100, 16'h0100, 1'b0);
    send(16'h0100, 16'h0100, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_valid", {15'd0, out_valid}, 16'd0);
    check("mid_rst_sum", out_sum, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("mid_rst_ready", {15'd0, in_ready}, 16'd1);
    check("mid_rst_valid2", {15'd0, out_valid}, 16'd0);
    send(16'h0100, 16'h0100, 1'b1);
    take("post_rst", 16'h0100, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
